double_flop_synchronizer: RTL and testbench
===========================================

Name: double_flop_synchronizer

Overview:
- Multi-stage flip-flop synchronizer that brings an asynchronous level signal (or bus of independent bits) into the clk2 domain.
- Sits at every clock-domain crossing point for single-bit control/status levels.
- Provides the synchronized level plus optional single-cycle rise/fall pulses derived from it.
- Not for multi-bit coherent data: each bit is synchronized independently.

Parameters:
- WIDTH, 1, number of independent bits synchronized.
- STAGES, 2, number of flip-flop stages in the chain; legal range 2..4, elaboration error outside it.
- RESET_VALUE, 0 (WIDTH bits), value loaded into every stage and the edge-detect register on reset.

Ports:
- clk2  input  1  destination-domain clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset, clk2 domain.
- in  input  WIDTH  asynchronous input level; no timing relationship to clk2 is assumed.
- out  output  WIDTH  synchronized level, the last stage of the chain.
- out_rise  output  WIDTH  one-cycle pulse per bit when out goes 0->1.
- out_fall  output  WIDTH  one-cycle pulse per bit when out goes 1->0.

Behaviour:
- Chain: sync[0] <= in; sync[k] <= sync[k-1] for k = 1..STAGES-1; out = sync[STAGES-1], driven directly from a flop with no logic after it.
- Latency: a value sampled by sync[0] at rising edge N appears on out after edge N+STAGES-1. For STAGES = 2, out follows in 1 to 2 clk2 periods after in changes, depending on phase.
- Input changing coincident with a clk2 edge may be captured at that edge or the next. Both outcomes are legal; sync[0] may go metastable, and the chain must give it a full period to resolve.
- Pulses shorter than one clk2 period may be lost; this is legal. No pulse stretching is done. Glitch-free output is guaranteed only for inputs stable at least one clk2 period.
- Edge detect: register out_d <= out.
  - out_rise = out & ~out_d
  - out_fall = ~out & out_d
  - Each pulse is high for exactly one cycle, in the same cycle out first shows the new value.
- Reset: when rst is sampled high at a rising edge, every sync stage and out_d load RESET_VALUE.
  - out = RESET_VALUE from the edge after rst is sampled high.
  - out_rise and out_fall are 0 during reset and in the first cycle after release.
- Reset released while in differs from RESET_VALUE: out reaches in STAGES edges after the first non-reset edge. The corresponding rise/fall pulse fires normally.
- Before the first reset, outputs are unknown; that is legal.
- No combinational path from in to any output.
- Synthesis attributes:
  - Mark all sync stages ASYNC_REG / dont_touch.
  - Keep them adjacent; no retiming.
  - No reset-to-async-flop optimization.

Decomposition:
- Shared package cdc_pkg holds:
  - the constants SYNC_STAGES_MIN = 2 and SYNC_STAGES_MAX = 4;
  - the default stage count SYNC_STAGES_DEFAULT = 2.
- One natural sub-module: sync_edge_detect, containing out_d and the rise/fall logic, parameterized by WIDTH and RESET_VALUE.
- The synchronizer chain itself stays in the top as a generate loop over STAGES.

Test Plan:
- Basic latency (WIDTH 1, STAGES 2, clk2 period 6 ns, first rising edge at 3 ns, reset held over edges 3 and 9):
  - Stimulus: in 0->1 at 11 ns.
  - Required: out = 0 through 21 ns; out = 1 from edge 21 ns; out_rise high exactly for the cycle starting at 21 ns.
- Falling edge:
  - Stimulus: in 1->0 between edges.
  - Required: out drops 2 edges after the first sampling edge; out_fall one cycle wide; out_rise stays 0.
- Short pulse:
  - Stimulus: in high for 4 ns, not spanning a rising edge.
  - Required: out stays 0; no rise/fall pulses.
  - Stimulus: a 4 ns pulse spanning one edge.
  - Required: out high for exactly one cycle; rise and fall pulses in consecutive cycles.
- Reset mid-operation:
  - Stimulus: in held at 1 and out = 1, then rst asserted for 1 cycle.
  - Required: out = 0 the cycle after reset; out = 1 again 2 edges after release; out_rise pulses once; out_fall is 0 throughout reset.
- Parameter sweep:
  - Stimulus: WIDTH 4, STAGES 3, RESET_VALUE 4'b1010; step in from 4'b1010 to 4'b0101.
  - Required: out changes to 4'b0101 exactly 3 edges after sampling; out_rise = 4'b0101 and out_fall = 4'b1010 for one cycle.
- Illegal STAGES:
  - Stimulus: elaborate with STAGES = 1 and with STAGES = 5.
  - Required: elaboration error in both cases.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing constants: legal synchronizer depth range and default.
package cdc_pkg;

    localparam int unsigned SYNC_STAGES_MIN     = 2;
    localparam int unsigned SYNC_STAGES_MAX     = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    function automatic bit sync_stages_legal(input int unsigned stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/double_flop_synchronizer_edge_detect.sv
// Rise/fall pulse generation from an already-synchronized level.
module sync_edge_detect #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] prev_q;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Both inputs are flop outputs, so the pulses are glitch-free.
    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/double_flop_synchronizer.sv
// Per-bit multi-stage synchronizer into the clk2 domain with rise/fall pulses.
module double_flop_synchronizer
    import cdc_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = SYNC_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall
);

    if (!sync_stages_legal(STAGES)) begin : g_bad_stages
        $error("double_flop_synchronizer: STAGES=%0d outside %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] sync_d;
        // Stages must stay adjacent and untouched so sync[0] gets a full period to resolve.
        (* ASYNC_REG = "TRUE", dont_touch = "true", keep = "true" *)
        logic [WIDTH-1:0] sync_q;

        if (k == 0) begin : g_first
            always_comb begin
                sync_d = in;
            end
        end else begin : g_next
            always_comb begin
                sync_d = stage_q[k-1];
            end
        end

        always_ff @(posedge clk2) begin
            if (rst) begin
                sync_q <= RESET_VALUE;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign stage_q[k] = sync_q;
    end

    assign out = stage_q[STAGES-1];

    sync_edge_detect #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_edge (
        .clk2  (clk2),
        .rst   (rst),
        .level (out),
        .rise  (out_rise),
        .fall  (out_fall)
    );

endmodule

// File: tb/tb_double_flop_synchronizer.sv
// Self-checking bench: directed latency/reset/pulse cases, vector table and random run vs timeline model.
module tb_double_flop_synchronizer;

    localparam int unsigned MAXE = 4096;
    localparam logic [3:0]  RV4  = 4'b1010;

    logic       clk2;
    logic       rst;
    logic       in1;
    logic       out1, rise1, fall1;
    logic [3:0] in4;
    logic [3:0] out4, rise4, fall4;

    double_flop_synchronizer #(.WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0)) dut1 (
        .clk2(clk2), .rst(rst), .in(in1), .out(out1), .out_rise(rise1), .out_fall(fall1)
    );

    double_flop_synchronizer #(.WIDTH(4), .STAGES(3), .RESET_VALUE(RV4)) dut4 (
        .clk2(clk2), .rst(rst), .in(in4), .out(out4), .out_rise(rise4), .out_fall(fall4)
    );

    initial begin
        clk2 = 1'b0;
        forever #3 clk2 = ~clk2;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Timeline model: what each clk2 edge saw on rst and the inputs.
    int         ecnt = 0;
    logic       rst_h [MAXE];
    logic       s1_h  [MAXE];
    logic [3:0] s4_h  [MAXE];

    always @(posedge clk2) begin
        if (ecnt < MAXE) begin
            rst_h[ecnt] = rst;
            s1_h[ecnt]  = in1;
            s4_h[ecnt]  = in4;
        end
        ecnt++;
    end

    // Output after edge k is the input sampled at edge k-S+1, unless any reset
    // landed at one of the S edges in between, in which case it is the reset value.
    function automatic logic [3:0] model_out(input int k, input bit wide);
        int s = wide ? 3 : 2;
        logic [3:0] rv = wide ? RV4 : 4'b0000;
        if (k < 0) return rv;
        for (int j = k - s + 1; j <= k; j++) begin
            if (j < 0 || rst_h[j]) return rv;
        end
        return wide ? s4_h[k-s+1] : {3'b000, s1_h[k-s+1]};
    endfunction

    function automatic logic [3:0] model_prev(input int k, input bit wide);
        if (rst_h[k]) return wide ? RV4 : 4'b0000;
        return model_out(k - 1, wide);
    endfunction

    always @(negedge clk2) begin
        if (ecnt >= 1 && ecnt <= MAXE) begin
            logic [3:0] eo, ep;
            for (int w = 0; w < 2; w++) begin
                eo = model_out(ecnt - 1, w != 0);
                ep = model_prev(ecnt - 1, w != 0);
                if (w == 0) begin
                    check("model_out1",  {3'b000, out1},  eo);
                    check("model_rise1", {3'b000, rise1}, eo & ~ep);
                    check("model_fall1", {3'b000, fall1}, ~eo & ep & 4'b0001);
                end else begin
                    check("model_out4",  out4,  eo);
                    check("model_rise4", rise4, eo & ~ep);
                    check("model_fall4", fall4, ~eo & ep);
                end
            end
        end
    end

    typedef struct {
        logic in;
        logic o;
        logic r;
        logic f;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in1 = 1'b0;
        in4 = RV4;

        // Reset held over edges 3 and 9.
        #10;
        rst = 1'b0;
        check("reset_out1",  {3'b000, out1},  4'b0000);
        check("reset_rise1", {3'b000, rise1}, 4'b0000);
        check("reset_fall1", {3'b000, fall1}, 4'b0000);
        check("reset_out4",  out4, RV4);
        check("reset_rise4", rise4, 4'b0000);

        // Basic latency: in rises at 11 ns, out follows from edge 21 ns.
        #1 in1 = 1'b1;
        #9;
        check("lat_out_before", {3'b000, out1}, 4'b0000);
        #2;
        check("lat_out_after", {3'b000, out1},  4'b0001);
        check("lat_rise",      {3'b000, rise1}, 4'b0001);
        #6;
        check("lat_rise_end",  {3'b000, rise1}, 4'b0000);

        // Falling edge between edges.
        @(negedge clk2);
        in1 = 1'b0;
        @(negedge clk2);
        check("fall_out_hold", {3'b000, out1},  4'b0001);
        check("fall_early",    {3'b000, fall1}, 4'b0000);
        @(negedge clk2);
        check("fall_out",      {3'b000, out1},  4'b0000);
        check("fall_pulse",    {3'b000, fall1}, 4'b0001);
        check("fall_no_rise",  {3'b000, rise1}, 4'b0000);
        @(negedge clk2);
        check("fall_pulse_end", {3'b000, fall1}, 4'b0000);

        for (int i = 0; i < 9; i++) begin
            in1 = tbl[i].in;
            @(negedge clk2);
            check($sformatf("tbl%0d_out", i),  {3'b000, out1},  {3'b000, tbl[i].o});
            check($sformatf("tbl%0d_rise", i), {3'b000, rise1}, {3'b000, tbl[i].r});
            check($sformatf("tbl%0d_fall", i), {3'b000, fall1}, {3'b000, tbl[i].f});
        end

        // Short pulse entirely between two edges is lost.
        @(posedge clk2);
        #1 in1 = 1'b1;
        #4 in1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2);
            check("short_out",  {3'b000, out1},  4'b0000);
            check("short_edge", {3'b000, rise1 | fall1}, 4'b0000);
        end

        // Short pulse spanning one edge.
        @(posedge clk2);
        #4 in1 = 1'b1;
        #4 in1 = 1'b0;
        @(negedge clk2);
        check("span_out0", {3'b000, out1}, 4'b0000);
        @(negedge clk2);
        check("span_out1", {3'b000, out1},  4'b0001);
        check("span_rise", {3'b000, rise1}, 4'b0001);
        @(negedge clk2);
        check("span_out2", {3'b000, out1},  4'b0000);
        check("span_fall", {3'b000, fall1}, 4'b0001);
        @(negedge clk2);
        check("span_quiet", {3'b000, rise1 | fall1}, 4'b0000);

        // Reset mid-operation with in held high.
        in1 = 1'b1;
        repeat (4) @(negedge clk2);
        check("rmid_pre", {3'b000, out1}, 4'b0001);
        rst = 1'b1;
        @(negedge clk2);
        rst = 1'b0;
        check("rmid_out_r",  {3'b000, out1},  4'b0000);
        check("rmid_fall_r", {3'b000, fall1}, 4'b0000);
        check("rmid_rise_r", {3'b000, rise1}, 4'b0000);
        @(negedge clk2);
        check("rmid_out_1",  {3'b000, out1},  4'b0000);
        check("rmid_edge_1", {3'b000, rise1 | fall1}, 4'b0000);
        @(negedge clk2);
        check("rmid_out_2",  {3'b000, out1},  4'b0001);
        check("rmid_rise_2", {3'b000, rise1}, 4'b0001);
        check("rmid_fall_2", {3'b000, fall1}, 4'b0000);
        @(negedge clk2);
        check("rmid_rise_3", {3'b000, rise1}, 4'b0000);

        // Wide instance: step from the reset value to its complement.
        in4 = 4'b0101;
        @(negedge clk2);
        check("w4_e0", out4, RV4);
        @(negedge clk2);
        check("w4_e1", out4, RV4);
        check("w4_e1_rise", rise4, 4'b0000);
        @(negedge clk2);
        check("w4_e2", out4, 4'b0101);
        check("w4_rise", rise4, 4'b0101);
        check("w4_fall", fall4, 4'b1010);
        @(negedge clk2);
        check("w4_quiet", rise4 | fall4, 4'b0000);

        // Random run, inputs and occasional resets changed away from edges.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk2);
            #(1 + ($urandom % 4));
            in1 = 1'($urandom);
            in4 = 4'($urandom);
            rst = (($urandom % 40) == 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
